// File: rtl/mux_arbiter4_pkg.sv
// Shared constants, state encoding and helpers for the four-way round-robin
// arbiter that drives the select of a registered 4-input multiplexer.
package mux_arbiter4_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_REQ-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/mux_arbiter4_if.sv
// Requester/arbiter bundle: request lines in, select/grant/status out.
interface mux_arbiter4_if;
  import mux_arbiter4_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [SEL_W-1:0]   control;
  logic [NUM_REQ-1:0] grant;
  logic               busy;
  logic               bus_valid;

  modport master (
    input  req,
    output control,
    output grant,
    output busy,
    output bus_valid
  );

  modport slave (
    output req,
    input  control,
    input  grant,
    input  busy,
    input  bus_valid
  );

endinterface

// File: rtl/mux_arbiter4_rr_pick4.sv
// Round-robin search: first requester strictly after 'last', wrapping, with
// 'last' itself tried at the very end.
module rr_pick4
  import mux_arbiter4_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   last,
  output logic [SEL_W-1:0]   idx,
  output logic               found
);

  logic [SEL_W-1:0] cand;

  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = last + SEL_W'(k);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_arbiter4.sv
// Round-robin owner selection with bounded hold time; bus_valid trails busy
// by one cycle to line up with the multiplexer's registered output.
module mux_arbiter4
  import mux_arbiter4_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic           clock,
  input  logic           reset_n,
  mux_arbiter4_if.master bus
);

  localparam int              HC_W     = $clog2(MAX_HOLD + 1);
  localparam logic [HC_W-1:0] HOLD_MAX = HC_W'(MAX_HOLD);
  localparam logic [HC_W-1:0] HOLD_ONE = HC_W'(1);

  state_t             state, state_next;
  logic [SEL_W-1:0]   owner, owner_next;
  logic [SEL_W-1:0]   last, last_next;
  logic [HC_W-1:0]    hold_cnt, hold_cnt_next;
  logic [NUM_REQ-1:0] grant, grant_next;
  logic [SEL_W-1:0]   control, control_next;
  logic               busy, busy_next;
  logic               bus_valid;

  logic [SEL_W-1:0]   pick_idx;
  logic               pick_found;
  logic               others;
  logic               take;

  rr_pick4 u_pick (
    .req   (bus.req),
    .last  (last),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign others = |(bus.req & ~onehot(owner));

  always_comb begin
    state_next    = state;
    owner_next    = owner;
    last_next     = last;
    hold_cnt_next = hold_cnt;
    grant_next    = grant;
    control_next  = control;
    busy_next     = busy;
    take          = 1'b0;

    unique case (state)
      IDLE: begin
        take = pick_found;
      end
      GRANT: begin
        if (!bus.req[owner]) begin
          if (pick_found) begin
            take = 1'b1;
          end else begin
            // control deliberately keeps the last owner's index
            state_next    = IDLE;
            grant_next    = '0;
            busy_next     = 1'b0;
            hold_cnt_next = '0;
          end
        end else if (hold_cnt == HOLD_MAX && others) begin
          take = 1'b1;
        end else if (hold_cnt != HOLD_MAX) begin
          hold_cnt_next = hold_cnt + HOLD_ONE;
        end
      end
      default: state_next = IDLE;
    endcase

    if (take) begin
      state_next    = GRANT;
      owner_next    = pick_idx;
      last_next     = pick_idx;
      control_next  = pick_idx;
      grant_next    = onehot(pick_idx);
      busy_next     = 1'b1;
      hold_cnt_next = HOLD_ONE;
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!reset_n) begin
      state     <= IDLE;
      owner     <= '0;
      last      <= SEL_W'(NUM_REQ - 1);
      hold_cnt  <= '0;
      grant     <= '0;
      control   <= '0;
      busy      <= 1'b0;
      bus_valid <= 1'b0;
    end else begin
      state     <= state_next;
      owner     <= owner_next;
      last      <= last_next;
      hold_cnt  <= hold_cnt_next;
      grant     <= grant_next;
      control   <= control_next;
      busy      <= busy_next;
      bus_valid <= busy;
    end
  end

  assign bus.grant     = grant;
  assign bus.control   = control;
  assign bus.busy      = busy;
  assign bus.bus_valid = bus_valid;

endmodule

// File: tb/tb_mux_arbiter4.sv
// Scoreboard bench: the driver queues the expected outputs for the cycle after
// each input change; a negedge monitor pops and compares them.
module tb_mux_arbiter4;

  logic clock;
  logic reset_n;
  int   cyc;
  int   tests;
  int   fails;

  typedef struct {
    int          cyc;
    int          dut;
    logic [3:0]  g;
    logic [1:0]  c;
    logic        b;
    logic        v;
    string       name;
  } exp_t;

  exp_t q[$];

  mux_arbiter4_if b4 ();
  mux_arbiter4_if b1 ();

  mux_arbiter4 #(.MAX_HOLD(4)) dut4 (.clock(clock), .reset_n(reset_n), .bus(b4));
  mux_arbiter4 #(.MAX_HOLD(1)) dut1 (.clock(clock), .reset_n(reset_n), .bus(b1));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc = cyc + 1;

  task automatic check(input exp_t e);
    logic [3:0] g;
    logic [1:0] c;
    logic       b;
    logic       v;
    if (e.dut == 4) begin
      g = b4.grant; c = b4.control; b = b4.busy; v = b4.bus_valid;
    end else begin
      g = b1.grant; c = b1.control; b = b1.busy; v = b1.bus_valid;
    end
    tests++;
    if (g !== e.g || c !== e.c || b !== e.b || v !== e.v) begin
      fails++;
      $display("FAIL %s cyc=%0d dut%0d: got grant=%b control=%0d busy=%b bus_valid=%b, want grant=%b control=%0d busy=%b bus_valid=%b",
               e.name, cyc, e.dut, g, c, b, v, e.g, e.c, e.b, e.v);
    end
  endtask

  // Monitor: compare every expectation due in the current cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        if (e.cyc < cyc) begin
          tests++;
          fails++;
          $display("FAIL %s stale expectation for cyc=%0d at cyc=%0d", e.name, e.cyc, cyc);
        end else begin
          check(e);
        end
      end
    end
  end

  task automatic step(input logic rst, input logic [3:0] r4, input logic [3:0] r1);
    @(posedge clock);
    #1;
    reset_n = rst;
    b4.req  = r4;
    b1.req  = r1;
  endtask

  task automatic expect_next(input int dut, input logic [3:0] g, input logic [1:0] c,
                             input logic b, input logic v, input string name);
    exp_t e;
    e.cyc = cyc + 1; e.dut = dut; e.g = g; e.c = c; e.b = b; e.v = v; e.name = name;
    q.push_back(e);
  endtask

  initial begin
    reset_n = 1'b0;
    b4.req  = 4'b1111;
    b1.req  = 4'b0000;
    expect_next(4, 4'b0000, 2'd0, 1'b0, 1'b0, "reset_c1");
    expect_next(1, 4'b0000, 2'd0, 1'b0, 1'b0, "reset_c1");
    step(1'b0, 4'b1111, 4'b0000);
    expect_next(4, 4'b0000, 2'd0, 1'b0, 1'b0, "reset_c2");
    expect_next(1, 4'b0000, 2'd0, 1'b0, 1'b0, "reset_c2");

    // dut4: first grant, release handover, hold limit. dut1: round robin.
    step(1'b1, 4'b1111, 4'b1111);
    expect_next(4, 4'b0001, 2'd0, 1'b1, 1'b0, "first_grant_r0");
    expect_next(1, 4'b0001, 2'd0, 1'b1, 1'b0, "rr_0");
    step(1'b1, 4'b0100, 4'b1111);
    expect_next(4, 4'b0100, 2'd2, 1'b1, 1'b1, "handover_0_to_2");
    expect_next(1, 4'b0010, 2'd1, 1'b1, 1'b1, "rr_1");
    step(1'b1, 4'b0100, 4'b1111);
    expect_next(4, 4'b0100, 2'd2, 1'b1, 1'b1, "hold2_cnt2");
    expect_next(1, 4'b0100, 2'd2, 1'b1, 1'b1, "rr_2");
    step(1'b1, 4'b0100, 4'b1111);
    expect_next(4, 4'b0100, 2'd2, 1'b1, 1'b1, "hold2_cnt3");
    expect_next(1, 4'b1000, 2'd3, 1'b1, 1'b1, "rr_3");
    step(1'b1, 4'b0100, 4'b1111);
    expect_next(4, 4'b0100, 2'd2, 1'b1, 1'b1, "hold2_cnt4");
    expect_next(1, 4'b0001, 2'd0, 1'b1, 1'b1, "rr_wrap_0");
    step(1'b1, 4'b0100, 4'b1111);
    expect_next(4, 4'b0100, 2'd2, 1'b1, 1'b1, "hold2_saturated");
    expect_next(1, 4'b0010, 2'd1, 1'b1, 1'b1, "rr_1b");
    step(1'b1, 4'b0101, 4'b1111);
    expect_next(4, 4'b0001, 2'd0, 1'b1, 1'b1, "preempt_2_to_0");
    expect_next(1, 4'b0100, 2'd2, 1'b1, 1'b1, "rr_2b");
    step(1'b1, 4'b0010, 4'b1111);
    expect_next(4, 4'b0010, 2'd1, 1'b1, 1'b1, "handover_0_to_1");
    expect_next(1, 4'b1000, 2'd3, 1'b1, 1'b1, "rr_3b");
    step(1'b1, 4'b1010, 4'b0000);
    expect_next(4, 4'b0010, 2'd1, 1'b1, 1'b1, "hold1_with_waiter");
    expect_next(1, 4'b0000, 2'd3, 1'b0, 1'b1, "rr_release_ctrl_holds");
    step(1'b1, 4'b1000, 4'b0000);
    expect_next(4, 4'b1000, 2'd3, 1'b1, 1'b1, "handover_1_to_3");
    expect_next(1, 4'b0000, 2'd3, 1'b0, 1'b0, "rr_idle_valid_low");
    step(1'b1, 4'b1001, 4'b0000);
    expect_next(4, 4'b1000, 2'd3, 1'b1, 1'b1, "hold3_with_waiter");
    step(1'b1, 4'b0001, 4'b0000);
    expect_next(4, 4'b0001, 2'd0, 1'b1, 1'b1, "handover_3_to_0_wrap");
    step(1'b1, 4'b0000, 4'b0000);
    expect_next(4, 4'b0000, 2'd0, 1'b0, 1'b1, "release_idle_tail");
    step(1'b1, 4'b0000, 4'b0000);
    expect_next(4, 4'b0000, 2'd0, 1'b0, 1'b0, "idle_valid_low");

    // Reset mid-grant, then a fresh count must allow four cycles before preemption.
    step(1'b1, 4'b0100, 4'b0000);
    expect_next(4, 4'b0100, 2'd2, 1'b1, 1'b0, "idle_grant_r2");
    step(1'b1, 4'b0100, 4'b0000);
    expect_next(4, 4'b0100, 2'd2, 1'b1, 1'b1, "r2_cnt2");
    step(1'b1, 4'b0100, 4'b0000);
    expect_next(4, 4'b0100, 2'd2, 1'b1, 1'b1, "r2_cnt3");
    step(1'b0, 4'b0100, 4'b0000);
    expect_next(4, 4'b0000, 2'd0, 1'b0, 1'b0, "reset_mid_grant");
    step(1'b1, 4'b0100, 4'b0000);
    expect_next(4, 4'b0100, 2'd2, 1'b1, 1'b0, "post_reset_grant_r2");
    step(1'b1, 4'b0101, 4'b0000);
    expect_next(4, 4'b0100, 2'd2, 1'b1, 1'b1, "fresh_cnt2");
    step(1'b1, 4'b0101, 4'b0000);
    expect_next(4, 4'b0100, 2'd2, 1'b1, 1'b1, "fresh_cnt3");
    step(1'b1, 4'b0101, 4'b0000);
    expect_next(4, 4'b0100, 2'd2, 1'b1, 1'b1, "fresh_cnt4");
    step(1'b1, 4'b0101, 4'b0000);
    expect_next(4, 4'b0001, 2'd0, 1'b1, 1'b1, "fresh_preempt_to_0");

    step(1'b1, 4'b0000, 4'b0000);
    repeat (3) @(posedge clock);
    @(negedge clock);
    #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
